// File: rtl/qcldpc_pkg.sv
// Shared types, default geometry and helpers for the QC-LDPC encoder control path.
package qcldpc_pkg;

  localparam int unsigned DEF_NUM_Z         = 3;
  localparam int unsigned DEF_NUM_INFO_BLKS = 20;
  localparam int unsigned DEF_NUM_PAR_BLKS  = 4;

  localparam int unsigned Z_VALUES [DEF_NUM_Z] = '{27, 54, 81};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DRAIN,
    ST_PARITY,
    ST_EMIT,
    ST_DONE
  } state_t;

  // Highest set bit wins; callers only use it on one-hot vectors.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/qcldpc_addr_gen.sv
// Proto-matrix ROM address mapping: row-major over TOTAL_BLKS columns,
// info columns during SHIFT, the diagonal parity entry during PARITY.
module qcldpc_addr_gen #(
  parameter int unsigned NUM_INFO_BLKS = 20,
  parameter int unsigned TOTAL_BLKS    = 24,
  parameter int unsigned ADDR_W        = 7,
  parameter int unsigned RW            = 2,
  parameter int unsigned CW            = 5
) (
  input  logic              shift_en,
  input  logic              parity_en,
  input  logic [RW-1:0]     row,
  input  logic [CW-1:0]     col,
  input  logic [RW-1:0]     par_idx,
  output logic [ADDR_W-1:0] addr
);

  always_comb begin
    addr = '0;
    if (shift_en) begin
      addr = ADDR_W'(32'(row) * TOTAL_BLKS + 32'(col));
    end else if (parity_en) begin
      addr = ADDR_W'(32'(par_idx) * TOTAL_BLKS + NUM_INFO_BLKS + 32'(par_idx));
    end
  end

endmodule

// File: rtl/qcldpc_enc_sequencer.sv
// Frame controller for the QC-LDPC encoder: info-block intake, ROM address
// stepping, accumulator/parity strobes and parity-block hand-out.
module qcldpc_enc_sequencer
  import qcldpc_pkg::*;
#(
  parameter int unsigned  NUM_Z         = DEF_NUM_Z,
  parameter int unsigned  NUM_INFO_BLKS = DEF_NUM_INFO_BLKS,
  parameter int unsigned  NUM_PAR_BLKS  = DEF_NUM_PAR_BLKS,
  localparam int unsigned TOTAL_BLKS    = NUM_INFO_BLKS + NUM_PAR_BLKS,
  parameter int unsigned  ADDR_W        = $clog2(TOTAL_BLKS * NUM_PAR_BLKS),
  localparam int unsigned ZW            = (NUM_Z > 1) ? $clog2(NUM_Z) : 1,
  localparam int unsigned RW            = (NUM_PAR_BLKS > 1) ? $clog2(NUM_PAR_BLKS) : 1
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [NUM_Z-1:0]  req_z,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              info_ld,
  output logic [ZW-1:0]     z_sel,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic [RW-1:0]     acc_row,
  output logic              par_en,
  output logic [RW-1:0]     par_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int unsigned   CW       = (NUM_INFO_BLKS > 1) ? $clog2(NUM_INFO_BLKS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_PAR_BLKS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(NUM_INFO_BLKS - 1);

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [RW-1:0] pidx;
  logic [ZW-1:0] z_q;
  logic          acc_pend;
  logic [RW-1:0] acc_row_q;
  logic          req_ok;
  logic          kill;

  assign req_ok = $onehot(req_z);
  assign kill   = abort && (state != ST_IDLE);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      row       <= '0;
      col       <= '0;
      pidx      <= '0;
      z_q       <= '0;
      acc_pend  <= 1'b0;
      acc_row_q <= '0;
    end else begin
      // ROM read latency: the accumulate strobe trails its SHIFT address by one cycle.
      acc_pend  <= (state == ST_SHIFT) && !kill;
      acc_row_q <= row;
      if (kill) begin
        state <= ST_IDLE;
        row   <= '0;
        col   <= '0;
        pidx  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && req_ok) begin
              z_q   <= ZW'(onehot_to_idx(32'(req_z)));
              row   <= '0;
              col   <= '0;
              pidx  <= '0;
              state <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (in_valid) begin
              row   <= '0;
              state <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (row == LAST_ROW) begin
              if (col == LAST_COL) begin
                state <= ST_DRAIN;
              end else begin
                col   <= col + 1'b1;
                state <= ST_LOAD;
              end
            end else begin
              row <= row + 1'b1;
            end
          end
          ST_DRAIN: begin
            pidx  <= '0;
            state <= ST_PARITY;
          end
          ST_PARITY: begin
            if (pidx == LAST_ROW) begin
              pidx  <= '0;
              state <= ST_EMIT;
            end else begin
              pidx <= pidx + 1'b1;
            end
          end
          ST_EMIT: begin
            if (out_ready) begin
              if (pidx == LAST_ROW) state <= ST_DONE;
              else                  pidx  <= pidx + 1'b1;
            end
          end
          ST_DONE: begin
            pidx  <= '0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  qcldpc_addr_gen #(
    .NUM_INFO_BLKS (NUM_INFO_BLKS),
    .TOTAL_BLKS    (TOTAL_BLKS),
    .ADDR_W        (ADDR_W),
    .RW            (RW),
    .CW            (CW)
  ) u_addr_gen (
    .shift_en  (state == ST_SHIFT),
    .parity_en (state == ST_PARITY),
    .row       (row),
    .col       (col),
    .par_idx   (pidx),
    .addr      (rom_addr)
  );

  assign in_ready  = (state == ST_LOAD) && !kill;
  assign info_ld   = in_valid && in_ready;
  assign z_sel     = z_q;
  assign acc_clr   = (state == ST_IDLE) && start && req_ok;
  assign cfg_err   = (state == ST_IDLE) && start && !req_ok;
  assign acc_en    = acc_pend && !kill;
  assign acc_row   = acc_en ? acc_row_q : '0;
  assign par_en    = (state == ST_PARITY) && !kill;
  assign out_valid = (state == ST_EMIT) && !kill;
  assign par_idx   = ((state == ST_PARITY) || (state == ST_EMIT)) ? pidx : '0;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE) && !kill;

endmodule

// File: tb/tb_qcldpc_enc_sequencer.sv
// Directed bench: a frame-schedule model predicts every output per cycle;
// a negedge compare process checks the DUT against it plus literal pins.
module tb_qcldpc_enc_sequencer;

  localparam int NI  = 20;
  localparam int NP  = 4;
  localparam int TOT = NI + NP;
  localparam int NC  = 600;
  localparam int END_CYC = 545;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic [2:0] req_z;
  logic       start, abort, in_valid, out_ready;
  logic       in_ready, info_ld, acc_clr, acc_en, par_en, out_valid, busy, done, cfg_err;
  logic [1:0] z_sel, acc_row, par_idx;
  logic [6:0] rom_addr;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  int s_start [NC], s_req [NC], s_inv [NC], s_ordy [NC], s_abort [NC];
  int e_inrdy [NC], e_ild [NC], e_z [NC], e_addr [NC], e_chka [NC], e_clr [NC];
  int e_acc [NC], e_row [NC], e_pen [NC], e_pidx [NC], e_ov [NC], e_busy [NC];
  int e_done [NC], e_cerr [NC];

  qcldpc_enc_sequencer #(
    .NUM_Z         (3),
    .NUM_INFO_BLKS (NI),
    .NUM_PAR_BLKS  (NP)
  ) dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .req_z     (req_z),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .info_ld   (info_ld),
    .z_sel     (z_sel),
    .rom_addr  (rom_addr),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .acc_row   (acc_row),
    .par_en    (par_en),
    .par_idx   (par_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 CLK = ~CLK;

  task automatic cmp(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", nm, c, act, exp_v);
    end
  endtask

  task automatic clear_exp(input int c0, input int zi);
    for (int c = c0; c < NC; c++) begin
      e_inrdy[c] = 0; e_ild[c] = 0; e_z[c] = zi; e_addr[c] = 0; e_chka[c] = 0;
      e_clr[c] = 0; e_acc[c] = 0; e_row[c] = 0; e_pen[c] = 0; e_pidx[c] = 0;
      e_ov[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_cerr[c] = 0;
    end
  endtask

  // Schedule one frame: start at t, optional in_valid gaps before blocks ga/gb,
  // optional out_ready stall on parity index sidx.
  task automatic plan_frame(input int t, input int req, input int zi,
                            input int ga, input int gb, input int glen,
                            input int sidx, input int slen, output int dn);
    int a, e;
    s_start[t] = 1; s_req[t] = req; e_clr[t] = 1;
    for (int c = t + 1; c < NC; c++) e_z[c] = zi;
    a = t + 1;
    for (int j = 0; j < NI; j++) begin
      if (j == ga || j == gb) begin
        for (int k = 0; k < glen; k++) begin
          s_inv[a] = 0; e_inrdy[a] = 1; a++;
        end
      end
      e_inrdy[a] = 1; e_ild[a] = 1;
      for (int r = 0; r < NP; r++) begin
        e_chka[a + 1 + r] = 1; e_addr[a + 1 + r] = r * TOT + j;
        e_acc[a + 2 + r]  = 1; e_row[a + 2 + r]  = r;
      end
      a += 1 + NP;
    end
    for (int p = 0; p < NP; p++) begin
      e_pen[a + 1 + p] = 1; e_pidx[a + 1 + p] = p;
      e_chka[a + 1 + p] = 1; e_addr[a + 1 + p] = p * TOT + NI + p;
    end
    e = a + 1 + NP;
    for (int p = 0; p < NP; p++) begin
      if (p == sidx) begin
        for (int s = 0; s < slen; s++) begin
          s_ordy[e] = 0; e_ov[e] = 1; e_pidx[e] = p; e++;
        end
      end
      e_ov[e] = 1; e_pidx[e] = p; e++;
    end
    e_done[e] = 1;
    for (int c = t + 1; c <= e; c++) e_busy[c] = 1;
    dn = e;
  endtask

  task automatic plan_abort(input int ab, input int zi);
    s_abort[ab] = 1;
    e_acc[ab] = 0; e_row[ab] = 0; e_pen[ab] = 0; e_ov[ab] = 0;
    e_done[ab] = 0; e_inrdy[ab] = 0; e_ild[ab] = 0; e_chka[ab] = 0;
    clear_exp(ab + 1, zi);
  endtask

  task automatic check_cycle(input int c);
    cmp("in_ready",  c, in_ready,  e_inrdy[c]);
    cmp("info_ld",   c, info_ld,   e_ild[c]);
    cmp("z_sel",     c, z_sel,     e_z[c]);
    cmp("acc_clr",   c, acc_clr,   e_clr[c]);
    cmp("acc_en",    c, acc_en,    e_acc[c]);
    cmp("par_en",    c, par_en,    e_pen[c]);
    cmp("out_valid", c, out_valid, e_ov[c]);
    cmp("busy",      c, busy,      e_busy[c]);
    cmp("done",      c, done,      e_done[c]);
    cmp("cfg_err",   c, cfg_err,   e_cerr[c]);
    cmp("addr_range", c, (rom_addr < 7'd96), 1);
    if (e_chka[c] != 0) cmp("rom_addr", c, rom_addr, e_addr[c]);
    if (e_acc[c] != 0) cmp("acc_row", c, acc_row, e_row[c]);
    if (e_pen[c] != 0 || e_ov[c] != 0) cmp("par_idx", c, par_idx, e_pidx[c]);
    // Hand-computed anchors for the schedule model.
    case (c)
      5:   cmp("pin_acc_clr", c, acc_clr, 1);
      6:   begin cmp("pin_info_ld", c, info_ld, 1); cmp("pin_z_sel", c, z_sel, 1); end
      8:   cmp("pin_addr_b0r1", c, rom_addr, 24);
      105: cmp("pin_addr_b19r3", c, rom_addr, 91);
      109: begin cmp("pin_addr_par2", c, rom_addr, 70); cmp("pin_pidx_par2", c, par_idx, 2); end
      115: cmp("pin_done", c, done, 1);
      116: cmp("pin_idle", c, busy, 0);
      120: cmp("pin_cfg_err", c, cfg_err, 1);
      248: cmp("pin_done_stall", c, done, 1);
      294: cmp("pin_abort_idle", c, busy, 0);
      297: cmp("pin_z_sel2", c, z_sel, 2);
      406: cmp("pin_done_after_abort", c, done, 1);
      default: ;
    endcase
  endtask

  initial begin
    start = 1'b0; req_z = '0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      start     = (s_start[cyc] != 0);
      req_z     = 3'(s_req[cyc]);
      abort     = (s_abort[cyc] != 0);
      in_valid  = (s_inv[cyc] != 0);
      out_ready = (s_ordy[cyc] != 0);
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (cyc >= 3 && cyc < NC) check_cycle(cyc);
    end
  end

  initial begin
    int dn;
    rst_n = 1'b0;
    for (int c = 0; c < NC; c++) begin
      s_start[c] = 0; s_req[c] = 0; s_inv[c] = 1; s_ordy[c] = 1; s_abort[c] = 0;
    end
    clear_exp(0, 0);

    plan_frame(5, 3'b010, 1, -1, -1, 0, -1, 0, dn);
    s_start[120] = 1; s_req[120] = 3'b011; e_cerr[120] = 1;
    s_start[123] = 1; s_req[123] = 3'b000; e_cerr[123] = 1;
    plan_frame(130, 3'b001, 0, 5, 19, 3, 2, 2, dn);
    plan_frame(255, 3'b010, 1, -1, -1, 0, -1, 0, dn);
    plan_abort(293, 1);
    plan_frame(296, 3'b100, 2, -1, -1, 0, -1, 0, dn);
    s_start[346] = 1; s_req[346] = 3'b001;
    s_start[398] = 1; s_req[398] = 3'b011;
    plan_frame(415, 3'b100, 2, -1, -1, 0, -1, 0, dn);
    clear_exp(522, 0);

    #22 rst_n = 1'b1;

    wait (cyc == 522);
    #3 rst_n = 1'b0;
    #1;
    cmp("rst_busy",      cyc, busy,      0);
    cmp("rst_out_valid", cyc, out_valid, 0);
    cmp("rst_par_idx",   cyc, par_idx,   0);
    cmp("rst_z_sel",     cyc, z_sel,     0);
    cmp("rst_done",      cyc, done,      0);
    cmp("rst_acc_en",    cyc, acc_en,    0);
    cmp("rst_rom_addr",  cyc, rom_addr,  0);
    cmp("rst_in_ready",  cyc, in_ready,  0);
    wait (cyc == 525);
    #3 rst_n = 1'b1;

    wait (cyc == END_CYC);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
